// File: rtl/ula_timing_pkg.sv
// ----------------------------------------------------------------------------
// ula_timing_pkg
// Shared ULA frame timing constants, contention FSM state type and the
// per-T-state contention delay lookup.
// ----------------------------------------------------------------------------
package ula_timing_pkg;

    // Frame geometry in CPU T-states and scanlines
    localparam int unsigned H_TSTATES  = 224;
    localparam int unsigned V_LINES    = 312;
    localparam int unsigned DISP_FIRST = 64;
    localparam int unsigned DISP_LINES = 192;

    // Contention window inside a display line
    localparam int unsigned CONT_START = 14;
    localparam int unsigned CONT_LEN   = 128;

    // Frame interrupt pulse length
    localparam int unsigned INT_LEN    = 32;

    // Counter and delay widths
    localparam int unsigned HCNT_W     = 8;
    localparam int unsigned VCNT_W     = 9;
    localparam int unsigned DLY_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } cont_state_t;

    // Delay pattern repeats every 8 T-states of the window: 6,5,4,3,2,1,0,0
    function automatic logic [DLY_W-1:0] cont_delay(input logic [2:0] p);
        logic [DLY_W-1:0] d;
        case (p)
            3'd0:    d = 3'd6;
            3'd1:    d = 3'd5;
            3'd2:    d = 3'd4;
            3'd3:    d = 3'd3;
            3'd4:    d = 3'd2;
            3'd5:    d = 3'd1;
            default: d = 3'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ula_beam_counter.sv
// ----------------------------------------------------------------------------
// ula_beam_counter
// Beam position in T-states (hcnt) and scanlines (vcnt), plus the registered
// active-low frame interrupt.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   ce_t      in   T-state strobe; counters advance only when high
//   hcnt      out  T-state within line, 0..H_TSTATES-1
//   vcnt      out  line within frame, 0..V_LINES-1
//   vs_nintr  out  low while vcnt==0 and hcnt<INT_LEN, one clk behind counters
// ----------------------------------------------------------------------------
module ula_beam_counter
    import ula_timing_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_t,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic              vs_nintr
);

    logic hwrap_c;
    logic vwrap_c;
    logic int_win_c;

    assign hwrap_c   = (hcnt == HCNT_W'(H_TSTATES - 1));
    assign vwrap_c   = (vcnt == VCNT_W'(V_LINES - 1));
    assign int_win_c = (vcnt == '0) && (hcnt < HCNT_W'(INT_LEN));

    // Horizontal / vertical position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce_t) begin
            if (hwrap_c) begin
                hcnt <= '0;
                vcnt <= vwrap_c ? '0 : vcnt + VCNT_W'(1);
            end else begin
                hcnt <= hcnt + HCNT_W'(1);
            end
        end
    end

    // Interrupt is sampled from the current counters every clk
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_nintr <= 1'b1;
        end else begin
            vs_nintr <= ~int_win_c;
        end
    end

endmodule

// File: rtl/ula_contention.sv
// ----------------------------------------------------------------------------
// ula_contention
// Contention scheduler: tracks the beam, raises the frame interrupt and holds
// the CPU T-state enable while video fetch owns contended RAM / ULA ports.
//
// Ports:
//   CLK       in   system clock (clk_ula domain)
//   RESET     in   synchronous active-high reset
//   ce_t      in   T-state strobe, one CLK wide per CPU T-state
//   turbo     in   1 = contention disabled, cpu_ce follows ce_t
//   mem_req   in   CPU memory request active
//   mem_cont  in   memory address/bank is contended
//   io_req    in   CPU IO request active
//   io_ula    in   IO address has A[0]=0
//   cpu_ce    out  gated T-state enable (combinational from ce_t and state)
//   vs_nintr  out  active-low frame interrupt
//   hcnt      out  T-state within line
//   vcnt      out  line within frame
//   stall     out  high while the CPU is held in WAIT
// ----------------------------------------------------------------------------
module ula_contention
    import ula_timing_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ce_t,
    input  logic              turbo,
    input  logic              mem_req,
    input  logic              mem_cont,
    input  logic              io_req,
    input  logic              io_ula,
    output logic              cpu_ce,
    output logic              vs_nintr,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic              stall
);

    cont_state_t      state;
    logic [DLY_W-1:0] wcnt;

    logic             creq_c;
    logic             in_lines_c;
    logic             in_cols_c;
    logic [2:0]       p_c;
    logic [DLY_W-1:0] delay_c;
    logic             hit_c;

    ula_beam_counter u_beam (
        .clk      (CLK),
        .reset    (RESET),
        .ce_t     (ce_t),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .vs_nintr (vs_nintr)
    );

    // Contention window and delay, from the counters at the request T-state
    assign creq_c     = (mem_req & mem_cont) | (io_req & io_ula);
    assign in_lines_c = (vcnt >= VCNT_W'(DISP_FIRST)) &&
                        (vcnt <  VCNT_W'(DISP_FIRST + DISP_LINES));
    assign in_cols_c  = (hcnt >= HCNT_W'(CONT_START)) &&
                        (hcnt <  HCNT_W'(CONT_START + CONT_LEN));
    assign p_c        = 3'(hcnt - HCNT_W'(CONT_START));
    assign delay_c    = (in_lines_c && in_cols_c) ? cont_delay(p_c) : '0;
    assign hit_c      = creq_c && !turbo && (delay_c != '0);

    // The request strobe itself is the first suppressed T-state, so WAIT
    // only has to swallow d-1 more; wcnt holds that remainder minus one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            wcnt  <= '0;
            stall <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ce_t && hit_c) begin
                        if (delay_c == DLY_W'(1)) begin
                            state <= GRANT;
                        end else begin
                            state <= WAIT;
                            wcnt  <= delay_c - DLY_W'(2);
                            stall <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (turbo || !creq_c) begin
                        state <= IDLE;
                        stall <= 1'b0;
                    end else if (ce_t) begin
                        if (wcnt == '0) begin
                            state <= GRANT;
                            stall <= 1'b0;
                        end else begin
                            wcnt <= wcnt - DLY_W'(1);
                        end
                    end
                end
                GRANT: begin
                    // One access is contended at most once
                    if (!creq_c) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    // T-state gate: never raised without ce_t; turbo always lets it through
    always_comb begin
        cpu_ce = ce_t;
        case (state)
            IDLE: begin
                if (hit_c) begin
                    cpu_ce = 1'b0;
                end
            end
            WAIT: begin
                if (!turbo) begin
                    cpu_ce = 1'b0;
                end
            end
            default: begin
                cpu_ce = ce_t;
            end
        endcase
    end

endmodule

// File: tb/tb_ula_contention.sv
// ----------------------------------------------------------------------------
// tb_ula_contention
// Scoreboarded bench: the driver pushes the expected per-access delay computed
// from beam position arithmetic; a monitor tracks a strobe-count beam model
// and pops/compares the delay when the CPU strobe finally passes.
// ----------------------------------------------------------------------------
module tb_ula_contention;

    localparam int H     = 224;
    localparam int V     = 312;
    localparam int FRAME = H * V;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ce_t;
    logic       turbo;
    logic       mem_req;
    logic       mem_cont;
    logic       io_req;
    logic       io_ula;
    logic       cpu_ce;
    logic       vs_nintr;
    logic [7:0] hcnt;
    logic [8:0] vcnt;
    logic       stall;

    int  n_cmp = 0;
    int  n_err = 0;
    int  drv_n = 0;
    bit  req_active = 0;
    bit  req_track  = 0;
    int  exp_q[$];

    always #5 CLK = ~CLK;

    ula_contention dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ce_t     (ce_t),
        .turbo    (turbo),
        .mem_req  (mem_req),
        .mem_cont (mem_cont),
        .io_req   (io_req),
        .io_ula   (io_ula),
        .cpu_ce   (cpu_ce),
        .vs_nintr (vs_nintr),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .stall    (stall)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: delay in T-states for a request issued at strobe index n
    function automatic int ref_delay(input int n, input bit mr, input bit mc,
                                     input bit ir, input bit iu, input bit tb);
        int h;
        int v;
        int p;
        h = n % H;
        v = (n / H) % V;
        if (tb || !((mr && mc) || (ir && iu))) return 0;
        if (v < 64 || v >= 64 + 192) return 0;
        if (h < 14 || h >= 14 + 128) return 0;
        p = (h - 14) % 8;
        return (p < 6) ? 6 - p : 0;
    endfunction

    // One CLK with the given strobe; reports whether the CPU saw a T-state
    task automatic cycle(input bit ce, output bit passed);
        ce_t = ce;
        @(negedge CLK);
        passed = ce && cpu_ce;
        @(posedge CLK);
        if (RESET) drv_n = 0;
        else if (ce) drv_n++;
        #1;
    endtask

    task automatic advance_to(input int target);
        bit p;
        while (drv_n < target) cycle(1'b1, p);
    endtask

    // mode 0: normal access, 1: raise turbo after 2 held strobes,
    // 2: assert RESET after 2 held strobes
    task automatic do_req(input bit mr, input bit mc, input bit ir, input bit iu,
                          input bit tb, input int mode, input bit gaps);
        int sup;
        int guard;
        bit passed;
        bit ce;
        sup = 0;
        guard = 0;
        passed = 0;
        if (mode == 0) exp_q.push_back(ref_delay(drv_n, mr, mc, ir, iu, tb));
        else if (mode == 1) exp_q.push_back(2);
        mem_req = mr; mem_cont = mc; io_req = ir; io_ula = iu; turbo = tb;
        req_track  = (mode != 2);
        req_active = 1'b1;
        cycle(1'b1, passed);
        if (!passed) sup++;
        while (!passed && guard < 40) begin
            ce = gaps ? ($urandom_range(3, 0) != 0) : 1'b1;
            if (mode == 1 && sup == 2 && !turbo) begin
                turbo = 1'b1;
                ce = 1'b0;
            end
            if (mode == 2 && sup == 2) begin
                req_active = 1'b0;
                mem_req = 0; mem_cont = 0; io_req = 0; io_ula = 0;
                RESET = 1'b1;
                cycle(1'b0, passed);
                RESET = 1'b0;
                return;
            end
            cycle(ce, passed);
            if (ce && !passed) sup++;
            guard++;
        end
        if (!passed) begin
            n_cmp++;
            n_err++;
            $display("FAIL access_bound: no cpu_ce after %0d strobes held", sup);
            exp_q.delete();
        end
        req_active = 1'b0;
        mem_req = 0; mem_cont = 0; io_req = 0; io_ula = 0; turbo = 0;
    endtask

    // Monitor: beam model, interrupt, gating rules and delay scoreboard
    initial begin : monitor
        int n;
        int eh;
        int ev;
        int ph;
        int pvv;
        int cnt;
        int exp_d;
        bit pv;
        n = 0; ph = 0; pvv = 0; cnt = 0; pv = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                n = 0;
                pv = 0;
                cnt = 0;
            end else begin
                eh = n % H;
                ev = (n / H) % V;
                check("hcnt", hcnt, eh);
                check("vcnt", vcnt, ev);
                check("vs_nintr", vs_nintr, (pv && pvv == 0 && ph < 32) ? 0 : 1);
                check("ce_without_strobe", cpu_ce & ~ce_t, 0);
                if (!req_active) begin
                    check("cpu_ce_idle", cpu_ce, ce_t);
                    check("stall_idle", stall, 0);
                    cnt = 0;
                end else if (req_track && ce_t) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL scoreboard_empty: strobe with no expected entry");
                    end else if (cpu_ce) begin
                        exp_d = exp_q.pop_front();
                        check("delay", cnt, exp_d);
                        check("stall_on_grant", stall, 0);
                        cnt = 0;
                    end else begin
                        check("stall_held", stall, (cnt > 0) ? 1 : 0);
                        cnt++;
                    end
                end
                pv = 1;
                ph = eh;
                pvv = ev;
                if (ce_t) n++;
            end
        end
    end

    initial begin : driver
        bit p;
        RESET = 1'b1; ce_t = 0; turbo = 0;
        mem_req = 0; mem_cont = 0; io_req = 0; io_ula = 0;
        repeat (3) cycle(1'b0, p);
        RESET = 1'b0;
        repeat (4) cycle(1'b0, p);

        // Directed positions: line 63, window start, pattern tail, edges
        advance_to(63 * H + 14);  do_req(1, 1, 0, 0, 0, 0, 0);
        advance_to(64 * H + 14);  do_req(1, 1, 0, 0, 0, 0, 0);
        advance_to(65 * H + 19);  do_req(1, 1, 0, 0, 0, 0, 0);
        advance_to(66 * H + 20);  do_req(1, 1, 0, 0, 0, 0, 0);
        advance_to(67 * H + 21);  do_req(1, 1, 0, 0, 0, 0, 0);
        advance_to(68 * H + 142); do_req(1, 1, 0, 0, 0, 0, 0);
        advance_to(69 * H + 14);  do_req(0, 0, 1, 0, 0, 0, 0);
        advance_to(69 * H + 40);  do_req(0, 0, 1, 1, 0, 0, 0);
        advance_to(70 * H + 14);  do_req(1, 1, 0, 0, 1, 0, 0);
        advance_to(71 * H + 14);  do_req(1, 1, 0, 0, 0, 1, 0);
        advance_to(71 * H + 134); do_req(1, 1, 0, 0, 0, 0, 0);
        advance_to(72 * H + 141); do_req(1, 1, 0, 0, 0, 0, 0);

        // Randomized accesses with strobe gaps across display lines
        advance_to(73 * H);
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(4, 0)) cycle(1'($urandom_range(1, 0)), p);
            do_req(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   ($urandom_range(7, 0) == 0), 0, 1);
        end

        // Frame wrap and next-frame interrupt, then reset mid-WAIT
        advance_to(FRAME + 64 * H + 14);
        do_req(1, 1, 0, 0, 0, 2, 0);
        repeat (40) cycle(1'b1, p);
        do_req(1, 1, 0, 0, 0, 0, 0);
        repeat (4) cycle(1'b1, p);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
